// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream framing constants for the instruction RAM loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs an LSB-first byte stream into 32-bit words.
// o_word is the word that completes on the current accepted byte; o_word_ready flags that byte.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Only three bytes are stored; the fourth comes straight from the input so the word is ready on the accept edge.
    assign o_word       = {i_byte, r_shift};
    assign o_word_ready = i_accept && (r_cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_accept) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader streaming a length-prefixed image into instruction RAM while holding the core.
// Optional trailing checksum stage is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int w     = 32,
    parameter int DEPTH = 2048
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   byte_data,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic         is_write,
    output logic [w-1:0] im_addr,
    output logic [w-1:0] im_inst,
    output logic         core_hold,
    output logic         load_done,
    output logic         load_err
);

    localparam int IW = $clog2(DEPTH + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [31:0]   r_len;
    logic [w-1:0]  r_addr;
    logic [w-1:0]  r_inst;
    logic          r_ready;
    logic          r_write;
    logic          r_hold;
    logic          r_done;
    logic          r_err;
    logic          w_accept;
    logic          w_clr;
    logic          w_more;
    logic          w_word_ready;
    logic [31:0]   w_word;

    assign w_accept = byte_valid && r_ready;
    assign w_clr    = (w_next == S_LEN) && (r_state != S_LEN);
    assign w_more   = (32'(r_idx) + 32'd1) < r_len;

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_accept     (w_accept),
        .i_byte       (byte_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || w_clr)
            r_sum <= '0;
        else if (r_state == S_DATA && w_word_ready)
            r_sum <= r_sum + w_word;
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_LEN : S_IDLE;
            S_LEN:   if (w_word_ready)
                         w_next = (w_word == 32'd0)       ? S_FIN :
                                  (w_word > 32'(DEPTH))   ? S_ERR : S_DATA;
            S_DATA:  w_next = w_word_ready ? S_WRITE : S_DATA;
            S_WRITE: w_next = w_more ? S_DATA : S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  if (w_word_ready)
                         w_next = (w_word == r_sum) ? S_DONE : S_ERR;
`endif
            S_DONE:  w_next = start ? S_LEN : S_DONE;
            S_ERR:   w_next = start ? S_LEN : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered yet line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_inst  <= '0;
            r_ready <= 1'b0;
            r_write <= 1'b0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= w_next inside {S_LEN, S_DATA, S_CSUM};
            r_write <= w_next == S_WRITE;
            r_hold  <= w_next != S_DONE;
            r_done  <= w_next == S_DONE;
            r_err   <= w_next == S_ERR;
            if (w_clr)
                r_idx <= '0;
            else if (r_state == S_WRITE)
                r_idx <= r_idx + 1'b1;
            if (r_state == S_LEN && w_word_ready)
                r_len <= w_word;
            if (r_state == S_DATA && w_word_ready) begin
                r_inst <= w'(w_word);
                r_addr <= w'(r_idx) << 2;
            end
        end
    end

    assign byte_ready = r_ready;
    assign is_write   = r_write;
    assign im_addr    = r_addr;
    assign im_inst    = r_inst;
    assign core_hold  = r_hold;
    assign load_done  = r_done;
    assign load_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads plus hand sequences; RAM writes are checked against a queue of expected words.
module tb_imem_loader;

    localparam int DEPTH = 2048;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
    } wr_t;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          gmax;
        logic        exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        is_write;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_writes = 0;
    wr_t exp_q[$];

    imem_loader #(.w(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .is_write   (is_write),
        .im_addr    (im_addr),
        .im_inst    (im_inst),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && is_write) begin
            wr_t e;
            n_writes++;
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %h inst %h expected no write", im_addr, im_inst);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", im_addr, e.addr);
                chk("write_inst", im_inst, e.inst);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k = 0;
        byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && k < 200) begin @(posedge clk); #1; k++; end
        if (!byte_ready) chk("byte_accept_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gmax);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t = d >> (8 * i);
            send_byte(t[7:0], $urandom_range(0, gmax));
        end
    endtask

    function automatic logic [31:0] gen_word(input int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    task automatic do_load(input int n, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int gmax);
        logic [31:0] d;
        logic [31:0] sum = 32'd0;
        pulse_start();
        send_word(32'(n), gmax);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                d = (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : gen_word(i);
                exp_q.push_back('{addr: 32'(i) * 32'd4, inst: d});
                send_word(d, gmax);
                sum += d;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_word(sum, gmax);
`endif
        end
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(load_done || load_err) && k < 100) begin @(posedge clk); #1; k++; end
        chk("end_reached", 32'(load_done || load_err), 32'd1);
    endtask

    vec_t tbl[5];

    initial begin
        int wb;
        tbl[0] = '{2,    32'h00100513, 32'h00200593, 32'h0,        0, 1'b1};
        tbl[1] = '{0,    32'h0,        32'h0,        32'h0,        0, 1'b1};
        tbl[2] = '{3,    32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 3, 1'b1};
        tbl[3] = '{1,    32'hA5A5A5A5, 32'h0,        32'h0,        5, 1'b1};
        tbl[4] = '{2049, 32'h0,        32'h0,        32'h0,        2, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_is_write",   32'(is_write),   32'd0);
        chk("rst_im_addr",    im_addr,         32'd0);
        chk("rst_im_inst",    im_inst,         32'd0);
        chk("rst_core_hold",  32'(core_hold),  32'd1);
        chk("rst_load_done",  32'(load_done),  32'd0);
        chk("rst_load_err",   32'(load_err),   32'd0);

        for (int r = 0; r < 5; r++) begin
            wb = n_writes;
            do_load(tbl[r].n, tbl[r].w0, tbl[r].w1, tbl[r].w2, tbl[r].gmax);
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (tbl[r].n == 0) chk("n0_done_immediately", 32'(load_done), 32'd1);
`endif
            wait_end();
            chk("vec_load_done",  32'(load_done),  32'(tbl[r].exp_done));
            chk("vec_load_err",   32'(load_err),   32'(!tbl[r].exp_done));
            chk("vec_core_hold",  32'(core_hold),  32'(!tbl[r].exp_done));
            chk("vec_ready_idle", 32'(byte_ready), 32'd0);
            chk("vec_write_count", 32'(n_writes - wb), 32'(tbl[r].n <= DEPTH ? tbl[r].n : 0));
            chk("vec_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        wb = n_writes;
        do_load(DEPTH, gen_word(0), gen_word(1), gen_word(2), 0);
        wait_end();
        chk("full_load_done", 32'(load_done), 32'd1);
        chk("full_last_addr", im_addr, 32'h1FFC);
        chk("full_write_count", 32'(n_writes - wb), 32'(DEPTH));

        pulse_start();
        send_word(32'd3, 1);
        exp_q.push_back('{addr: 32'd0, inst: 32'h11111111});
        send_word(32'h11111111, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
        chk("midrst_is_write",   32'(is_write),   32'd0);
        chk("midrst_im_addr",    im_addr,         32'd0);
        chk("midrst_im_inst",    im_inst,         32'd0);
        chk("midrst_core_hold",  32'(core_hold),  32'd1);
        chk("midrst_load_done",  32'(load_done),  32'd0);
        chk("midrst_load_err",   32'(load_err),   32'd0);
        do_load(3, 32'h22222222, 32'h33333333, 32'h44444444, 1);
        wait_end();
        chk("reload_done", 32'(load_done), 32'd1);
        chk("reload_queue_empty", 32'(exp_q.size()), 32'd0);

        pulse_start();
        send_word(32'd2, 0);
        exp_q.push_back('{addr: 32'd0, inst: 32'h0A0B0C0D});
        send_word(32'h0A0B0C0D, 0);
        exp_q.push_back('{addr: 32'd4, inst: 32'h01020304});
        send_byte(8'h04, 0);
        send_byte(8'h03, 0);
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0A0B0C0D + 32'h01020304, 0);
`endif
        wait_end();
        chk("start_in_data_done", 32'(load_done), 32'd1);
        chk("start_in_data_queue", 32'(exp_q.size()), 32'd0);

        pulse_start();
        chk("restart_core_hold",  32'(core_hold),  32'd1);
        chk("restart_load_done",  32'(load_done),  32'd0);
        chk("restart_byte_ready", 32'(byte_ready), 32'd1);
        send_word(32'd1, 0);
        exp_q.push_back('{addr: 32'd0, inst: 32'h0BADC0DE});
        send_word(32'h0BADC0DE, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h0BADC0DE, 0);
`endif
        wait_end();
        chk("restart_done", 32'(load_done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int c = 0; c < 2; c++) begin
            pulse_start();
            send_word(32'd2, 0);
            exp_q.push_back('{addr: 32'd0, inst: 32'h00100513});
            send_word(32'h00100513, 0);
            exp_q.push_back('{addr: 32'd4, inst: 32'h00200593});
            send_word(32'h00200593, 0);
            send_word(c == 0 ? 32'h00300AA6 : 32'h00300AA7, 0);
            wait_end();
            chk("csum_done", 32'(load_done), 32'(c == 0));
            chk("csum_err",  32'(load_err),  32'(c != 0));
        end
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time sequencer for the instruction RAM write port. It takes a byte stream from the host link (UART/debug bridge) with a valid/ready handshake and packs the bytes into little-endian 32-bit words. Each word goes out on the instruction RAM's `is_write`/`im_addr`/`im_inst` port. The pipelined core is held in reset until the image has been written completely.

## Interface
Parameters:
- `w`, 32: data/address width; must match the instruction RAM `w`.
- `DEPTH`, 2048: instruction RAM capacity in words; the maximum image length.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in other states.
- `byte_data` input 8: incoming stream byte.
- `byte_valid` input 1: `byte_data` valid.
- `byte_ready` output 1: loader can accept a byte; a byte transfers when `byte_valid && byte_ready`.
- `is_write` output 1: instruction RAM write strobe.
- `im_addr` output w: byte address of the written word (word_idx << 2).
- `im_inst` output w: word to write.
- `core_hold` output 1: holds the core and PC in reset while high.
- `load_done` output 1: high while in DONE.
- `load_err` output 1: high while in ERR.

## Operation
- Stream format: 4-byte length header `N` (word count, LSB first), then N words, each LSB byte first.
- States and transitions:
  - IDLE goes to LEN on `start`.
  - LEN gathers 4 bytes.
  - After LEN: N == 0 goes to DONE; N > DEPTH goes to ERR; otherwise goes to DATA.
  - DATA gathers 4 bytes, then goes to WRITE.
  - WRITE asserts `is_write` for one cycle, then increments word_idx. It returns to DATA if word_idx+1 < N. Otherwise it goes to DONE, or to CSUM when the checksum feature is built.
  - DONE and ERR go to LEN on `start`. Reload clears word_idx and sets `core_hold` again.
- Byte packing: byte k of a word (k = 0..3) lands in bits [8k+7:8k]. The byte counter is 2 bits and wraps 3 to 0, completing the word.
- `byte_ready` = 1 only in LEN, DATA and CSUM. It is 0 in IDLE, WRITE, DONE and ERR, which gives back-pressure while writing.
- word_idx width is clog2(DEPTH+1). `im_addr` = word_idx zero-extended to w and shifted left by 2.
- `core_hold` = 1 in every state except DONE.
- `start` arriving during LEN, DATA, WRITE or CSUM is ignored and does not abort the load.
- Reset in any state returns to IDLE. RAM contents already written stay unchanged but count as invalid.

## Timing
- Reset values:
  - `byte_ready` = 0, `is_write` = 0, `im_addr` = 0, `im_inst` = 0.
  - `core_hold` = 1, `load_done` = 0, `load_err` = 0.
  - State IDLE; word_idx, byte counter and length all 0.
- All outputs are registered.
- Latency: the cycle after the 4th byte of a word is accepted, `is_write` = 1 with `im_addr` and `im_inst` stable. They stay stable for that one cycle, and the RAM samples them on the following edge.
- Word throughput: at most 1 word per 5 cycles (4 accept cycles plus 1 WRITE cycle).
- `core_hold` falls on the same edge that `load_done` rises.
- In DONE, `im_addr` and `im_inst` hold their last values and `is_write` stays 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE, the loader enters CSUM and gathers a 4-byte LSB-first checksum.
  - Expected value is the sum of all N data words, modulo 2^32.
  - Match goes to DONE; mismatch goes to ERR.
  - For N == 0 the path is LEN to CSUM, with the expected sum = 0.
- `IMEM_LOADER_CHECKSUM_EN` undefined: there is no CSUM state and no accumulator; the last WRITE goes directly to DONE.

## Structure
- Shared package `imem_loader_pkg`:
  - State enum (IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR).
  - `HDR_BYTES` = 4 and `WORD_BYTES` = 4.
- Sub-module `imem_word_packer`: byte-to-word shift register with 2-bit byte counter, `word_ready` pulse and clear input. It is reused by LEN, DATA and CSUM.

## Test plan
- Basic load:
  - Stimulus: `start`, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00.
  - Required: two `is_write` pulses, (`im_addr` 0x0, `im_inst` 0x00100513) and (`im_addr` 0x4, `im_inst` 0x00200593); then `load_done` = 1 and `core_hold` = 0.
- Back-pressure and gaps:
  - Stimulus: random `byte_valid` gaps while checking `byte_ready` in each state.
  - Required: `byte_ready` = 0 on every WRITE cycle; no byte is lost or duplicated; final RAM image matches the stream.
- Boundaries:
  - Stimulus: N = 0, then N = DEPTH (2048 words), then N = 2049.
  - Required: N = 0 goes to DONE immediately with no writes. N = 2048 gives a last `im_addr` of 0x1FFC. N = 2049 gives `load_err` = 1, `core_hold` = 1 and no writes.
- Reset mid-load:
  - Stimulus: assert `rst` after word 1 of 3 is written, then `start` and a full stream.
  - Required: all outputs take their reset values the cycle after `rst`. The reload then writes from `im_addr` 0x0.
- Checksum (with `IMEM_LOADER_CHECKSUM_EN`):
  - Stimulus: the basic-load stream, followed by checksum 0x00300AA6 in one run and a wrong checksum in another.
  - Required: correct checksum gives `load_done`; wrong checksum gives `load_err`.
- Reload and ignored `start`:
  - Stimulus: `start` pulsed during DATA; `start` pulsed in DONE.
  - Required: `start` in DATA is ignored. `start` in DONE sets `core_hold` = 1 the next cycle and enters LEN.
